// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between memory writeback (fixed priority)
// and ALU writeback (bypass when idle, otherwise queued in order), and flags pending-write read hazards.
module regfile_write_arbiter #(
    parameter int DW    = 64,
    parameter int AW    = 5,
    parameter int DEPTH = 2
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         MemValid,
    input  logic [AW-1:0]                MemRd,
    input  logic [DW-1:0]                MemData,
    input  logic                         AluValid,
    output logic                         AluReady,
    input  logic [AW-1:0]                AluRd,
    input  logic [DW-1:0]                AluData,
    output logic [AW-1:0]                RW,
    output logic [DW-1:0]                BusW,
    output logic                         RegWr,
    input  logic [AW-1:0]                RA,
    input  logic [AW-1:0]                RB,
    output logic                         HazA,
    output logic                         HazB,
    output logic [$clog2(DEPTH+1)-1:0]   Count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [AW-1:0] ZERO_REG = {AW{1'b1}};

    // Handshake: an ALU write is taken when AluValid && AluReady at a rising edge;
    // AluReady depends only on the pre-edge Count, so a full buffer never passes through.
    logic [AW-1:0] bufRd   [DEPTH];
    logic [DW-1:0] bufData [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    logic aluAcc;
    logic aluWr;
    logic memWr;
    logic bufNonEmpty;
    logic pop;
    logic bypass;
    logic push;

    assign AluReady    = Reset_n && (Count < CW'(DEPTH));
    assign aluAcc      = AluValid && AluReady;
    assign aluWr       = aluAcc && (AluRd != ZERO_REG);
    assign memWr       = MemValid && (MemRd != ZERO_REG);
    assign bufNonEmpty = (Count != '0);
    assign pop         = !memWr && bufNonEmpty;
    assign bypass      = !memWr && !bufNonEmpty && aluWr;
    assign push        = aluWr && !bypass;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            RW    <= '0;
            BusW  <= '0;
            RegWr <= 1'b0;
            head  <= '0;
            tail  <= '0;
            Count <= '0;
        end else begin
            if (memWr) begin
                RW    <= MemRd;
                BusW  <= MemData;
                RegWr <= 1'b1;
            end else if (pop) begin
                RW    <= bufRd[head];
                BusW  <= bufData[head];
                RegWr <= 1'b1;
            end else if (bypass) begin
                RW    <= AluRd;
                BusW  <= AluData;
                RegWr <= 1'b1;
            end else begin
                RegWr <= 1'b0;
            end
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            Count <= Count + CW'(push) - CW'(pop);
        end
    end

    // Buffer storage carries no reset; validity is tracked entirely by head/Count.
    always_ff @(posedge Clk) begin
        if (Reset_n && push) begin
            bufRd[tail]   <= AluRd;
            bufData[tail] <= AluData;
        end
    end

    logic hitA;
    logic hitB;

    always_comb begin
        hitA = RegWr && (RW == RA);
        hitB = RegWr && (RW == RB);
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < Count) begin
                if (bufRd[head + PW'(k)] == RA) hitA = 1'b1;
                if (bufRd[head + PW'(k)] == RB) hitB = 1'b1;
            end
        end
    end

    assign HazA = (RA != ZERO_REG) && hitA;
    assign HazB = (RB != ZERO_REG) && hitB;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed-vector bench for regfile_write_arbiter: inputs change 1ns after each rising edge,
// registered outputs are checked right after that and combinational ones after inputs settle.
module tb_regfile_write_arbiter;
    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          MemValid;
    logic [AW-1:0] MemRd;
    logic [DW-1:0] MemData;
    logic          AluValid;
    logic          AluReady;
    logic [AW-1:0] AluRd;
    logic [DW-1:0] AluData;
    logic [AW-1:0] RW;
    logic [DW-1:0] BusW;
    logic          RegWr;
    logic [AW-1:0] RA;
    logic [AW-1:0] RB;
    logic          HazA;
    logic          HazB;
    logic [CW-1:0] Count;

    int testsRun    = 0;
    int testsFailed = 0;

    regfile_write_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .MemValid(MemValid), .MemRd(MemRd), .MemData(MemData),
        .AluValid(AluValid), .AluReady(AluReady), .AluRd(AluRd), .AluData(AluData),
        .RW(RW), .BusW(BusW), .RegWr(RegWr),
        .RA(RA), .RB(RB), .HazA(HazA), .HazB(HazB), .Count(Count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] mdata,
                         input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] adata);
        MemValid = mv;
        MemRd    = mrd;
        MemData  = mdata;
        AluValid = av;
        AluRd    = ard;
        AluData  = adata;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Checks one registered write-port state.
    task automatic checkPort(input string tag, input logic wr, input logic [AW-1:0] rd,
                             input logic [DW-1:0] data, input logic [CW-1:0] cnt);
        check({tag, ".RegWr"}, 64'(RegWr), 64'(wr));
        if (wr) begin
            check({tag, ".RW"}, 64'(RW), 64'(rd));
            check({tag, ".BusW"}, BusW, data);
        end
        check({tag, ".Count"}, 64'(Count), 64'(cnt));
    endtask

    initial begin
        Reset_n = 1'b0;
        RA = 5'd0;
        RB = 5'd0;
        drive(1'b1, 5'd7, 64'h77, 1'b1, 5'd8, 64'h88);
        #1;
        check("rst.AluReadyComb", 64'(AluReady), 64'd0);

        // Reset held for two edges with both sources valid
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("rst.RegWr", 64'(RegWr), 64'd0);
            check("rst.RW", 64'(RW), 64'd0);
            check("rst.BusW", BusW, 64'd0);
            check("rst.AluReady", 64'(AluReady), 64'd0);
            check("rst.Count", 64'(Count), 64'd0);
        end
        Reset_n = 1'b1;
        AluValid = 1'b0;
        #1;
        check("rel.AluReady", 64'(AluReady), 64'd1);
        cycle();
        checkPort("rel.first", 1'b1, 5'd7, 64'h77, 2'd0);
        idle();
        cycle();
        check("rel.idleRegWr", 64'(RegWr), 64'd0);
        check("rel.holdRW", 64'(RW), 64'd7);

        // Bypass with empty buffer
        RA = 5'd5;
        drive(1'b0, '0, '0, 1'b1, 5'd5, 64'h1234);
        #1;
        check("byp.HazAbefore", 64'(HazA), 64'd0);
        cycle();
        checkPort("byp", 1'b1, 5'd5, 64'h1234, 2'd0);
        check("byp.HazA", 64'(HazA), 64'd1);
        idle();
        cycle();
        check("byp.after.RegWr", 64'(RegWr), 64'd0);
        check("byp.after.HazA", 64'(HazA), 64'd0);

        // Collision: Mem wins, ALU queued
        RB = 5'd4;
        drive(1'b1, 5'd3, 64'hA, 1'b1, 5'd4, 64'hB);
        cycle();
        checkPort("col.c1", 1'b1, 5'd3, 64'hA, 2'd1);
        check("col.c1.HazB", 64'(HazB), 64'd1);
        idle();
        cycle();
        checkPort("col.c2", 1'b1, 5'd4, 64'hB, 2'd0);
        check("col.c2.HazB", 64'(HazB), 64'd1);
        cycle();
        check("col.c3.RegWr", 64'(RegWr), 64'd0);
        check("col.c3.HazB", 64'(HazB), 64'd0);

        // Backpressure: four Mem cycles while ALU offers Rd=1,2,3
        drive(1'b1, 5'd10, 64'h110, 1'b1, 5'd1, 64'h201);
        #1;
        check("bp.c1.AluReady", 64'(AluReady), 64'd1);
        cycle();
        checkPort("bp.c1", 1'b1, 5'd10, 64'h110, 2'd1);
        drive(1'b1, 5'd11, 64'h111, 1'b1, 5'd2, 64'h202);
        #1;
        check("bp.c2.AluReady", 64'(AluReady), 64'd1);
        cycle();
        checkPort("bp.c2", 1'b1, 5'd11, 64'h111, 2'd2);
        drive(1'b1, 5'd12, 64'h112, 1'b1, 5'd3, 64'h203);
        #1;
        check("bp.c3.AluReady", 64'(AluReady), 64'd0);
        cycle();
        checkPort("bp.c3", 1'b1, 5'd12, 64'h112, 2'd2);
        drive(1'b1, 5'd13, 64'h113, 1'b1, 5'd3, 64'h203);
        #1;
        check("bp.c4.AluReady", 64'(AluReady), 64'd0);
        cycle();
        checkPort("bp.c4", 1'b1, 5'd13, 64'h113, 2'd2);
        drive(1'b0, '0, '0, 1'b1, 5'd3, 64'h203);
        #1;
        check("bp.c5.AluReady", 64'(AluReady), 64'd0);
        cycle();
        checkPort("bp.c5", 1'b1, 5'd1, 64'h201, 2'd1);
        #1;
        check("bp.c6.AluReady", 64'(AluReady), 64'd1);
        cycle();
        checkPort("bp.c6", 1'b1, 5'd2, 64'h202, 2'd1);
        idle();
        cycle();
        checkPort("bp.c7", 1'b1, 5'd3, 64'h203, 2'd0);
        cycle();
        checkPort("bp.c8", 1'b0, '0, '0, 2'd0);

        // Zero register handling
        drive(1'b0, '0, '0, 1'b1, 5'd31, 64'hDEAD);
        #1;
        check("zr.AluReady", 64'(AluReady), 64'd1);
        cycle();
        checkPort("zr.alu31", 1'b0, '0, '0, 2'd0);
        drive(1'b1, 5'd20, 64'h14, 1'b1, 5'd21, 64'h15);
        cycle();
        checkPort("zr.fill", 1'b1, 5'd20, 64'h14, 2'd1);
        drive(1'b1, 5'd31, 64'hFF, 1'b0, '0, '0);
        cycle();
        checkPort("zr.mem31drain", 1'b1, 5'd21, 64'h15, 2'd0);
        idle();
        RA = 5'd31;
        cycle();
        checkPort("zr.idle", 1'b0, '0, '0, 2'd0);
        check("zr.HazA31", 64'(HazA), 64'd0);

        // Mid-operation reset drops buffered entries
        RA = 5'd23;
        RB = 5'd25;
        drive(1'b1, 5'd22, 64'h16, 1'b1, 5'd23, 64'h17);
        cycle();
        checkPort("mr.c1", 1'b1, 5'd22, 64'h16, 2'd1);
        drive(1'b1, 5'd24, 64'h18, 1'b1, 5'd25, 64'h19);
        cycle();
        checkPort("mr.c2", 1'b1, 5'd24, 64'h18, 2'd2);
        check("mr.HazA", 64'(HazA), 64'd1);
        check("mr.HazB", 64'(HazB), 64'd1);
        idle();
        Reset_n = 1'b0;
        #1;
        check("mr.AluReadyComb", 64'(AluReady), 64'd0);
        cycle();
        check("mr.rst.RegWr", 64'(RegWr), 64'd0);
        check("mr.rst.RW", 64'(RW), 64'd0);
        check("mr.rst.BusW", BusW, 64'd0);
        check("mr.rst.Count", 64'(Count), 64'd0);
        check("mr.rst.HazA", 64'(HazA), 64'd0);
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checkPort("mr.post", 1'b0, '0, '0, 2'd0);
            check("mr.post.HazB", 64'(HazB), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
